pipe_mem_arbiter: RTL and testbench
===================================

Name: pipe_mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the IF stage (instruction fetch) and the MEM stage (load/store driven by the EX/MEM register's control_mem bits).
- Sequences one transaction at a time, returns data and done pulses to the owning stage, and drives pipeline stall.
- Enforces MEM-first priority with an IF starvation guard, cancels fetches on exception, and flags bus timeouts.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles waiting for ram_ack before bus error (1..255).

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST_N  in  1  asynchronous active-low reset.
- if_req  in  1  IF fetch request; level, held until if_done.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word; valid with if_done.
- if_done  out  1  one-cycle pulse when fetch completes.
- mem_read  in  1  MEM load request; level.
- mem_write  in  1  MEM store request; level. Read and write both high: write wins.
- mem_addr  in  ADDR_W  load/store address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data; valid with mem_done.
- mem_done  out  1  one-cycle pulse when load/store completes.
- exception_disable  in  1  exception flush; cancels IF ownership.
- ram_req  out  1  memory request, held until ram_ack.
- ram_we  out  1  write enable, qualified by ram_req.
- ram_addr  out  ADDR_W  memory address.
- ram_wdata  out  DATA_W  memory write data.
- ram_rdata  in  DATA_W  memory read data; valid with ram_ack.
- ram_ack  in  1  memory completion pulse.
- stall  out  1  freezes the pipeline registers.
- bus_error  out  1  sticky timeout flag.

Behaviour:
- Reset (RST_N low, async): state IDLE; all outputs 0; rdata registers 0; timeout counter 0; starve counter 0; bus_error 0.
- FSM states: IDLE, GNT_IF, GNT_MEM, DRAIN, ERROR. All outputs are registered.
- IDLE arbitration (one decision per cycle):
  - MEM request (mem_read|mem_write) wins, unless starve_cnt==2 and if_req; then IF wins.
  - Otherwise if_req -> GNT_IF.
  - No request: stay IDLE.
  - Grant latches address, wdata and we into ram_* regs. ram_req rises the cycle after the request is sampled (1-cycle grant latency).
- GNT_x: ram_req held with stable address/data until ram_ack.
  - On ram_ack: capture ram_rdata into if_rdata or mem_rdata (stores leave mem_rdata unchanged); pulse the matching done next cycle; return to IDLE.
  - Back-to-back transactions therefore cost one idle cycle between them.
- starve_cnt (2 bits):
  - +1 on each MEM grant while if_req is high (saturates at 2).
  - Cleared on any IF grant or when if_req is low at a MEM grant.
- exception_disable:
  - In GNT_IF: go to DRAIN; keep ram_req until ram_ack; discard data; no if_done; then IDLE.
  - In IDLE: IF requests are ignored that cycle.
  - MEM transactions are unaffected.
- Timeout: counter resets at each grant and increments each cycle in GNT_x/DRAIN without ack. Reaching TIMEOUT -> ERROR: ram_req dropped; bus_error=1; done pulses never issued; stall held 1. Only RST_N leaves ERROR.
- stall = 1 when:
  - any request is pending and not yet done, or
  - state is DRAIN or ERROR.
  - stall drops in the same cycle the done pulse rises.
- ram_ack outside GNT_x/DRAIN is ignored.
- Reset mid-transaction: everything clears immediately; ram_req falls asynchronously.

Test Plan:
- IF only, addr 0x100, ram_ack 3 cycles after ram_req with rdata 0xDEADBEEF -> if_done pulse, if_rdata=0xDEADBEEF; stall high from request until the done cycle.
- if_req and mem_read together, mem_addr 0x2000 -> MEM granted first, then IF; ram_addr sequence 0x2000, then the IF address; one idle cycle between.
- mem_read held continuously for 3 transactions with if_req high -> grants MEM, MEM, IF (starvation guard); starve_cnt clears after the IF grant.
- Store 0x12345678 to 0x40 with mem_read also high -> ram_we=1, ram_wdata=0x12345678; mem_done pulses; mem_rdata unchanged.
- exception_disable during GNT_IF, ack 2 cycles later -> DRAIN, no if_done, return to IDLE; a following mem_read is served normally.
- TIMEOUT=8 with no ram_ack -> bus_error=1 after 8 cycles, ram_req=0, stall=1; RST_N low clears all outputs to 0.

Source files
------------

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between the IF and MEM pipeline stages.
// MEM wins by default; IF is forced through after two MEM grants it waited on.
module pipe_mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    input  logic              exception_disable,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              stall,
    output logic              bus_error
);

    typedef enum logic [2:0] {StIdle, StGntIf, StGntMem, StDrain, StError} state_e;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [1:0]        starve_q, starve_d;
    logic              ram_req_q, ram_req_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic              stall_q, stall_d;
    logic              bus_error_q, bus_error_d;

    logic mem_any;
    logic if_ok;

    assign mem_any = mem_read | mem_write;
    assign if_ok   = if_req & ~exception_disable;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        ram_req_d   = ram_req_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        stall_d     = stall_q;
        bus_error_d = bus_error_q;

        case (state_q)
            StIdle: begin
                stall_d = mem_any | if_req;
                if (mem_any && !(starve_q == 2'd2 && if_ok)) begin
                    state_d     = StGntMem;
                    ram_req_d   = 1'b1;
                    ram_we_d    = mem_write;
                    ram_addr_d  = mem_addr;
                    ram_wdata_d = mem_wdata;
                    cnt_d       = '0;
                    if (!if_req) begin
                        starve_d = 2'd0;
                    end else if (starve_q != 2'd2) begin
                        starve_d = starve_q + 2'd1;
                    end
                end else if (if_ok) begin
                    state_d     = StGntIf;
                    ram_req_d   = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = if_addr;
                    ram_wdata_d = '0;
                    cnt_d       = '0;
                    starve_d    = 2'd0;
                end
            end
            StGntIf, StGntMem, StDrain: begin
                if (ram_ack) begin
                    state_d   = StIdle;
                    ram_req_d = 1'b0;
                    ram_we_d  = 1'b0;
                    stall_d   = 1'b0;
                    if (state_q == StGntMem) begin
                        mem_done_d = 1'b1;
                        if (!ram_we_q) begin
                            mem_rdata_d = ram_rdata;
                        end
                    end else if (state_q == StGntIf && !exception_disable) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = ram_rdata;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    state_d     = StError;
                    ram_req_d   = 1'b0;
                    ram_we_d    = 1'b0;
                    stall_d     = 1'b1;
                    bus_error_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                    stall_d = 1'b1;
                    // A flushed fetch must still see its ack before the bus is free again.
                    if (state_q == StGntIf && exception_disable) begin
                        state_d = StDrain;
                    end
                end
            end
            StError: begin
                ram_req_d = 1'b0;
                stall_d   = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            starve_q    <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            stall_q     <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            stall_q     <= stall_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_done   = if_done_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_done  = mem_done_q;
    assign stall     = stall_q;
    assign bus_error = bus_error_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: vector table, directed corner sequences and a
// randomized run against a transaction-level model with a small RAM behind the DUT.
module tb_pipe_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        exception_disable = 1'b0;
    logic        ram_req;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        ram_ack = 1'b0;
    logic        stall;
    logic        bus_error;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(8)
    ) dut (
        .CLK              (clk),
        .RST_N            (rst_n),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_rdata         (if_rdata),
        .if_done          (if_done),
        .mem_read         (mem_read),
        .mem_write        (mem_write),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_done         (mem_done),
        .exception_disable(exception_disable),
        .ram_req          (ram_req),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .ram_rdata        (ram_rdata),
        .ram_ack          (ram_ack),
        .stall            (stall),
        .bus_error        (bus_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          ifr;
        bit          mr;
        bit          mw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          dly;
        bit          exp_we;
        logic [31:0] exp_if_rdata;
        logic [31:0] exp_mem_rdata;
        bit          exp_if_done;
        bit          exp_mem_done;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_req"}, ram_req, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_ram_addr"}, ram_addr, 0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
        chk({tag, "_if_rdata"}, if_rdata, 0);
        chk({tag, "_mem_rdata"}, mem_rdata, 0);
        chk({tag, "_dones"}, {30'b0, if_done, mem_done}, 0);
        chk({tag, "_stall"}, stall, 0);
        chk({tag, "_bus_error"}, bus_error, 0);
    endtask

    task automatic clear_reqs();
        if_req    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        exception_disable = 1'b0;
    endtask

    task automatic wait_req(input string name);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ram_req) break;
        end
        chk({name, "_req_seen"}, ram_req, 1);
    endtask

    task automatic ack_after(input int dly, input logic [31:0] rd);
        for (int k = 0; k < dly; k++) begin
            chk("hold_req", ram_req, 1);
            @(negedge clk);
        end
        ram_ack   = 1'b1;
        ram_rdata = rd;
        @(negedge clk);
        ram_ack   = 1'b0;
        ram_rdata = '0;
    endtask

    vec_t        vecs[6];
    logic [31:0] memarr[16];

    // Random-run model state
    bit          if_pend, mem_pend, m_we, ack_drv;
    logic [31:0] if_a, m_a, m_wd, exp_if_rd, exp_mem_rd;
    int          owner, exp_owner, waits, ack_cnt, n_tx, if_age, sel;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 3, 1'b0,
                    32'hDEADBEEF, 32'h0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 32'hCAFEF00D, 0, 1'b0,
                    32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h40, 32'h12345678, 32'hBAD0BAD0, 1, 1'b1,
                    32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h44, 32'hA5A5A5A5, 32'h11111111, 2, 1'b1,
                    32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h00000013, 0, 1'b0,
                    32'h00000013, 32'hCAFEF00D, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h48, 32'h0, 32'h00000007, 4, 1'b0,
                    32'h00000013, 32'h00000007, 1'b0, 1'b1};

        // Reset state
        @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table: one transaction each
        for (int i = 0; i < 6; i++) begin
            if_req    = vecs[i].ifr;
            if_addr   = vecs[i].ifr ? vecs[i].addr : 32'h0;
            mem_read  = vecs[i].mr;
            mem_write = vecs[i].mw;
            mem_addr  = vecs[i].addr;
            mem_wdata = vecs[i].wdata;
            wait_req($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].addr);
            chk($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].exp_we);
            if (vecs[i].exp_we) chk($sformatf("vec%0d_ram_wdata", i), ram_wdata, vecs[i].wdata);
            chk($sformatf("vec%0d_stall_busy", i), stall, 1);
            ack_after(vecs[i].dly, vecs[i].rdata);
            chk($sformatf("vec%0d_if_done", i), if_done, vecs[i].exp_if_done);
            chk($sformatf("vec%0d_mem_done", i), mem_done, vecs[i].exp_mem_done);
            chk($sformatf("vec%0d_if_rdata", i), if_rdata, vecs[i].exp_if_rdata);
            chk($sformatf("vec%0d_mem_rdata", i), mem_rdata, vecs[i].exp_mem_rdata);
            chk($sformatf("vec%0d_stall_done", i), stall, 0);
            clear_reqs();
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), {30'b0, if_done, mem_done}, 0);
            chk($sformatf("vec%0d_idle_req", i), ram_req, 0);
        end

        // IF and MEM together: MEM first, then IF after one idle cycle
        if_req = 1'b1; if_addr = 32'h300; mem_read = 1'b1; mem_addr = 32'h2000;
        wait_req("both");
        chk("both_first_addr", ram_addr, 32'h2000);
        ack_after(1, 32'h55);
        chk("both_mem_done", mem_done, 1);
        chk("both_if_not_done", if_done, 0);
        chk("both_mem_rdata", mem_rdata, 32'h55);
        chk("both_idle_gap", ram_req, 0);
        mem_read = 1'b0;
        @(negedge clk);
        chk("both_second_req", ram_req, 1);
        chk("both_second_addr", ram_addr, 32'h300);
        ack_after(0, 32'h66);
        chk("both_if_done", if_done, 1);
        chk("both_if_rdata", if_rdata, 32'h66);
        clear_reqs();
        @(negedge clk);

        // Starvation guard: both held, grant pattern MEM, MEM, IF, repeating
        if_req = 1'b1; if_addr = 32'h600; mem_read = 1'b1; mem_addr = 32'h500;
        for (int k = 0; k < 6; k++) begin
            wait_req($sformatf("starve%0d", k));
            chk($sformatf("starve%0d_addr", k), ram_addr, (k % 3 == 2) ? 32'h600 : 32'h500);
            ack_after(0, 32'h1000 + k);
            chk($sformatf("starve%0d_if_done", k), if_done, (k % 3 == 2) ? 1 : 0);
            chk($sformatf("starve%0d_mem_done", k), mem_done, (k % 3 == 2) ? 0 : 1);
        end
        clear_reqs();
        @(negedge clk);

        // Exception during an IF grant: drain, no if_done, then MEM is served
        if_req = 1'b1; if_addr = 32'h700;
        wait_req("exc");
        exception_disable = 1'b1;
        @(negedge clk);
        exception_disable = 1'b0; if_req = 1'b0;
        chk("exc_drain_stall", stall, 1);
        @(negedge clk);
        chk("exc_drain_req", ram_req, 1);
        ram_ack = 1'b1; ram_rdata = 32'hBADBAD00;
        @(negedge clk);
        ram_ack = 1'b0;
        chk("exc_no_done", if_done, 0);
        chk("exc_req_drop", ram_req, 0);
        chk("exc_stall_clear", stall, 0);
        chk("exc_if_rdata_kept", if_rdata, 32'h1005);
        mem_read = 1'b1; mem_addr = 32'h800;
        wait_req("exc_mem");
        chk("exc_mem_addr", ram_addr, 32'h800);
        ack_after(1, 32'h99);
        chk("exc_mem_done", mem_done, 1);
        chk("exc_mem_rdata", mem_rdata, 32'h99);
        clear_reqs();
        @(negedge clk);

        // Exception in IDLE blocks IF requests
        if_req = 1'b1; if_addr = 32'h704; exception_disable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("exc_idle_blocked", ram_req, 0);
        exception_disable = 1'b0;
        wait_req("exc_idle");
        chk("exc_idle_addr", ram_addr, 32'h704);
        ack_after(0, 32'h77);
        chk("exc_idle_if_done", if_done, 1);
        chk("exc_idle_if_rdata", if_rdata, 32'h77);
        clear_reqs();
        @(negedge clk);

        // Timeout: ram_req held 8 cycles, then sticky error
        mem_read = 1'b1; mem_addr = 32'h900;
        wait_req("tmo");
        for (int k = 1; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("tmo_req_%0d", k), ram_req, 1);
            chk($sformatf("tmo_noerr_%0d", k), bus_error, 0);
        end
        @(negedge clk);
        chk("tmo_req_drop", ram_req, 0);
        chk("tmo_bus_error", bus_error, 1);
        chk("tmo_stall", stall, 1);
        ram_ack = 1'b1;
        @(negedge clk);
        ram_ack = 1'b0;
        @(negedge clk);
        chk("tmo_late_ack_ignored", mem_done, 0);
        chk("tmo_error_sticky", bus_error, 1);
        chk("tmo_stall_sticky", stall, 1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("tmo_reset");
        clear_reqs();
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a transaction drops ram_req without a clock edge
        mem_read = 1'b1; mem_addr = 32'hA00;
        wait_req("midrst");
        #2 rst_n = 1'b0;
        #1 chk("midrst_ram_req", ram_req, 0);
        chk("midrst_stall", stall, 0);
        clear_reqs();
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic against a transaction-level model
        for (int i = 0; i < 16; i++) memarr[i] = $urandom();
        if_pend = 0; mem_pend = 0; ack_drv = 0; owner = 0; waits = 0;
        n_tx = 0; if_age = 0; exp_if_rd = '0; exp_mem_rd = '0; m_we = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (ack_drv) begin
                ram_ack = 1'b0;
                ack_drv = 0;
                chk("rnd_req_drop", ram_req, 0);
                chk("rnd_stall_done", stall, 0);
                if (owner == 1) begin
                    exp_if_rd = memarr[if_a[5:2]];
                    chk("rnd_if_done", if_done, 1);
                    chk("rnd_if_quiet_mem", mem_done, 0);
                    chk("rnd_if_rdata", if_rdata, exp_if_rd);
                    if_pend = 0; if_req = 1'b0;
                end else begin
                    if (m_we) memarr[m_a[5:2]] = m_wd;
                    else      exp_mem_rd = memarr[m_a[5:2]];
                    chk("rnd_mem_done", mem_done, 1);
                    chk("rnd_mem_quiet_if", if_done, 0);
                    chk("rnd_mem_rdata", mem_rdata, exp_mem_rd);
                    mem_pend = 0; mem_read = 1'b0; mem_write = 1'b0;
                end
                owner = 0;
                n_tx++;
            end else begin
                chk("rnd_no_done", {30'b0, if_done, mem_done}, 0);
                if (owner == 0 && ram_req) begin
                    if (mem_pend && !(waits == 2 && if_pend)) exp_owner = 2;
                    else if (if_pend)                         exp_owner = 1;
                    else                                      exp_owner = 0;
                    if (exp_owner == 2) begin
                        chk("rnd_mem_addr", ram_addr, m_a);
                        chk("rnd_mem_we", ram_we, m_we);
                        if (m_we) chk("rnd_mem_wdata", ram_wdata, m_wd);
                        waits = if_pend ? ((waits < 2) ? waits + 1 : 2) : 0;
                    end else if (exp_owner == 1) begin
                        chk("rnd_if_addr", ram_addr, if_a);
                        chk("rnd_if_we", ram_we, 0);
                        waits = 0;
                    end else begin
                        chk("rnd_spurious_grant", ram_req, 0);
                    end
                    chk("rnd_stall_busy", stall, 1);
                    owner   = exp_owner;
                    ack_cnt = $urandom_range(0, 3);
                end else if (owner != 0) begin
                    chk("rnd_req_held", ram_req, 1);
                end
                if (owner != 0) begin
                    if (ack_cnt == 0) begin
                        ram_ack   = 1'b1;
                        ack_drv   = 1;
                        ram_rdata = (owner == 2 && m_we) ? $urandom() : memarr[ram_addr[5:2]];
                    end else begin
                        ack_cnt--;
                    end
                end
            end
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1;
                if_a    = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
                if_req  = 1'b1;
                if_addr = if_a;
            end
            if (!mem_pend && $urandom_range(0, 2) == 0) begin
                mem_pend  = 1;
                m_a       = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
                m_wd      = $urandom();
                sel       = $urandom_range(0, 2);
                m_we      = (sel != 0);
                mem_read  = (sel != 1);
                mem_write = m_we;
                mem_addr  = m_a;
                mem_wdata = m_wd;
            end
            if (if_pend) if_age++;
            else         if_age = 0;
            if (if_age == 80) chk("rnd_if_starved", if_age, 0);
        end
        chk("rnd_progress", (n_tx > 200) ? 1 : 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
